led_frame_builder: RTL and testbench

Upstream feeder for the 32x8 LED matrix SPI driver (four cascaded MAX7219-style devices).
- The CPU writes an 8-row x 32-column bitmap into this block, then pulses a commit.
- The block expands the bitmap into the driver's 132-word command image and writes that image through the driver's write port.
- It then raises the driver's start interrupt.
- All MAX7219 word formatting and the driver handshake live here, so the CPU only deals in pixels.

---
 rtl/led_pkg.sv | 38 +++
 rtl/led_word_gen.sv | 48 ++++
 rtl/led_frame_builder.sv | 190 +++++++++++++++++++
 tb/tb_led_frame_builder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED matrix frame builder:
//   - FSM state encoding for led_frame_builder
//   - MAX7219 register addresses
//   - image geometry (device count, rows, init-word count)
//   - mk_word(): packs a register/data pair into a 16-bit driver word
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_WRITE    = 3'd2,
        ST_START    = 3'd3,
        ST_ACK      = 3'd4
    } fsm_state_t;

    // MAX7219 register addresses
    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDN    = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    localparam int NUM_DEVICES = 4;
    localparam int ROWS        = 8;
    localparam int INIT_WORDS  = 20;

    // Driver word layout: {4'h0, register, data}
    function automatic logic [15:0] mk_word(input logic [3:0] reg_addr,
                                            input logic [7:0] data);
        return {4'h0, reg_addr, data};
    endfunction

endpackage

// File: rtl/led_word_gen.sv
// ---------------------------------------------------------------------------
// led_word_gen
// Combinational mapper from a driver image word index to the 16-bit word
// stored at that index.
//   in_idx    : image word index (0..NUM_WORDS-1)
//   in_shadow : frozen bitmap, row r = in_shadow[r], bit 31 = leftmost column
//   out_word  : {4'h0, reg, data}
// Layout: words 0..19 init commands (4 per command), words 20..51 rows 0..7
// (4 per row, device 3 first), everything beyond is a no-op word.
// ---------------------------------------------------------------------------
module led_word_gen
    import led_pkg::*;
#(
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic [7:0]            in_idx,
    input  logic [ROWS-1:0][31:0] in_shadow,
    output logic [15:0]           out_word
);

    logic [2:0] w_row;
    logic [1:0] w_dev;

    // Word selection: init table, row data, or no-op
    always_comb begin
        // Row and device derived from the offset past the init block; device 3
        // occupies the first slot of each group of four.
        w_row    = 3'((in_idx - 8'(INIT_WORDS)) >> 2);
        w_dev    = 2'd3 - 2'(in_idx - 8'(INIT_WORDS));
        out_word = 16'h0000;
        if (in_idx < 8'(INIT_WORDS)) begin
            case (in_idx[4:2])
                3'd0:    out_word = mk_word(REG_DECODE,    8'h00);
                3'd1:    out_word = mk_word(REG_INTENSITY, {4'h0, INTENSITY});
                3'd2:    out_word = mk_word(REG_SCANLIM,   8'h07);
                3'd3:    out_word = mk_word(REG_SHUTDN,    8'h01);
                3'd4:    out_word = mk_word(REG_TEST,      8'h00);
                default: out_word = mk_word(REG_NOOP,      8'h00);
            endcase
        end else if (in_idx < 8'(INIT_WORDS + ROWS * NUM_DEVICES)) begin
            out_word = mk_word(REG_DIGIT0 + {1'b0, w_row},
                               in_shadow[w_row][{w_dev, 3'b000} +: 8]);
        end else begin
            out_word = mk_word(REG_NOOP, 8'h00);
        end
    end

endmodule

// File: rtl/led_frame_builder.sv
// ---------------------------------------------------------------------------
// led_frame_builder
// Builds the 132-word MAX7219 command image for a 32x8 matrix (four cascaded
// devices) from a CPU-written bitmap, writes it into the SPI driver RAM and
// pulses the driver start interrupt.
//
// Ports:
//   in_clk, in_rst          clock, asynchronous active-low reset
//   in_bm_data/addr/we      CPU bitmap row write (bit 31 = leftmost column)
//   in_commit               one-cycle send request
//   in_IR_READY             driver idle / frame-complete flag
//   out_data/addr/we        driver RAM write port
//   out_IR_START            one-cycle driver start pulse
//   out_busy                commit accepted, driver not yet acknowledged
//
// Optional feature macro: LED_FB_AUTO_REFRESH_EN
//   When defined, an idle counter raises an internal commit every
//   REFRESH_DIV idle cycles so the matrix is periodically resent.
// ---------------------------------------------------------------------------
module led_frame_builder
    import led_pkg::*;
#(
    parameter logic [3:0]  INTENSITY   = 4'h8,
    parameter int          NUM_WORDS   = 132,
    parameter logic [23:0] REFRESH_DIV = 24'd1000000
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic [31:0] in_bm_data,
    input  logic [2:0]  in_bm_addr,
    input  logic        in_bm_we,
    input  logic        in_commit,
    input  logic        in_IR_READY,
    output logic [15:0] out_data,
    output logic [7:0]  out_addr,
    output logic        out_we,
    output logic        out_IR_START,
    output logic        out_busy
);

    localparam logic [7:0] LAST_ADDR = 8'(NUM_WORDS - 1);

    fsm_state_t            r_state;
    logic [7:0]            r_cnt;
    logic                  r_pending;
    logic [ROWS-1:0][31:0] r_bitmap;
    logic [ROWS-1:0][31:0] r_shadow;
    logic                  w_commit;
    logic [7:0]            w_idx;
    logic [15:0]           w_word;

`ifdef LED_FB_AUTO_REFRESH_EN
    logic [23:0] r_idle_cnt;
    logic        w_auto_commit;

    // Auto-refresh request when the idle counter reaches its terminal count
    always_comb begin
        if ((r_state == ST_IDLE) && (r_idle_cnt == (REFRESH_DIV - 24'd1))) begin
            w_auto_commit = 1'b1;
        end else begin
            w_auto_commit = 1'b0;
        end
    end

    assign w_commit = in_commit | w_auto_commit;

    // Idle counter: counts only while idle, restarts on any commit
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_idle_cnt <= 24'd0;
        end else if ((r_state != ST_IDLE) || w_commit) begin
            r_idle_cnt <= 24'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 24'd1;
        end
    end
`else
    logic w_unused_refresh;

    assign w_commit         = in_commit;
    assign w_unused_refresh = ^REFRESH_DIV;
`endif

    // Outputs are registered one word ahead: the index fed to the word
    // generator is the address that becomes visible after the next edge.
    always_comb begin
        if (r_state == ST_WRITE) begin
            w_idx = r_cnt + 8'd1;
        end else begin
            w_idx = 8'd0;
        end
    end

    led_word_gen #(
        .INTENSITY (INTENSITY)
    ) u_word_gen (
        .in_idx    (w_idx),
        .in_shadow (r_shadow),
        .out_word  (w_word)
    );

    // CPU bitmap row writes, accepted in every state
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_bitmap <= '0;
        end else if (in_bm_we) begin
            r_bitmap[in_bm_addr] <= in_bm_data;
        end else begin
            r_bitmap <= r_bitmap;
        end
    end

    // Frame FSM: shadow capture, image write-out, start pulse, driver ack
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_pending    <= 1'b0;
            r_shadow     <= '0;
            out_data     <= 16'h0000;
            out_addr     <= 8'd0;
            out_we       <= 1'b0;
            out_IR_START <= 1'b0;
            out_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    out_we       <= 1'b0;
                    out_IR_START <= 1'b0;
                    if (w_commit || r_pending) begin
                        out_busy <= 1'b1;
                        r_state  <= ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (in_IR_READY) begin
                        // A commit in this very cycle may carry a bitmap write
                        // that misses the capture, so it keeps pending set.
                        r_shadow  <= r_bitmap;
                        r_pending <= w_commit;
                        r_cnt     <= 8'd0;
                        out_we    <= 1'b1;
                        out_addr  <= 8'd0;
                        out_data  <= w_word;
                        r_state   <= ST_WRITE;
                    end else if (w_commit) begin
                        r_pending <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (w_commit) begin
                        r_pending <= 1'b1;
                    end
                    if (r_cnt == LAST_ADDR) begin
                        out_we       <= 1'b0;
                        out_IR_START <= 1'b1;
                        r_state      <= ST_START;
                    end else begin
                        r_cnt    <= r_cnt + 8'd1;
                        out_addr <= r_cnt + 8'd1;
                        out_data <= w_word;
                    end
                end
                ST_START: begin
                    if (w_commit) begin
                        r_pending <= 1'b1;
                    end
                    out_IR_START <= 1'b0;
                    r_state      <= ST_ACK;
                end
                ST_ACK: begin
                    if (w_commit) begin
                        r_pending <= 1'b1;
                    end
                    if (!in_IR_READY) begin
                        out_busy <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    out_we       <= 1'b0;
                    out_IR_START <= 1'b0;
                    out_busy     <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_builder.sv
`timescale 1ns/1ps
module tb_led_frame_builder;

    localparam int NW = 132;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b0;
    logic [31:0] in_bm_data = 32'h0;
    logic [2:0]  in_bm_addr = 3'd0;
    logic        in_bm_we = 1'b0;
    logic        in_commit = 1'b0;
    logic        in_IR_READY = 1'b1;
    logic [15:0] out_data;
    logic [7:0]  out_addr;
    logic        out_we;
    logic        out_IR_START;
    logic        out_busy;

    led_frame_builder #(
        .INTENSITY   (4'h8),
        .NUM_WORDS   (NW),
        .REFRESH_DIV (24'd100)
    ) dut (
        .in_clk       (in_clk),
        .in_rst       (in_rst),
        .in_bm_data   (in_bm_data),
        .in_bm_addr   (in_bm_addr),
        .in_bm_we     (in_bm_we),
        .in_commit    (in_commit),
        .in_IR_READY  (in_IR_READY),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .out_we       (out_we),
        .out_IR_START (out_IR_START),
        .out_busy     (out_busy)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int commit_cyc = 0;
    int first_we_cyc = 0;
    int start_cyc = 0;
    int n_start = 0;
    int exp_addr = 0;
    bit chk_en = 1'b0;

    logic [31:0]  tb_bm [8];
    logic [255:0] frame_q [$];
    logic [255:0] cur_frame = '0;
    logic [15:0]  cap [256];

    always @(posedge in_clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] pack_bm();
        logic [255:0] p;
        for (int r = 0; r < 8; r++) p[32*r +: 32] = tb_bm[r];
        return p;
    endfunction

    // Expected driver word straight from the image layout rules
    function automatic logic [15:0] model_word(input int idx, input logic [255:0] fr);
        int r;
        int d;
        if (idx < 20) begin
            case (idx / 4)
                0:       return 16'h0900;
                1:       return 16'h0A08;
                2:       return 16'h0B07;
                3:       return 16'h0C01;
                4:       return 16'h0F00;
                default: return 16'h0000;
            endcase
        end else if (idx < 52) begin
            r = (idx - 20) / 4;
            d = 3 - ((idx - 20) % 4);
            return {4'h0, 4'(r + 1), fr[32*r + 8*d +: 8]};
        end
        return 16'h0000;
    endfunction

    // Compare process: every driver write and start pulse against the model
    always @(negedge in_clk) begin
        if (chk_en) begin
            if (out_we) begin
                if (exp_addr == 0) begin
                    first_we_cyc = cyc;
                    chk("frame_queued", 32'(frame_q.size() != 0), 32'd1);
                    if (frame_q.size() != 0) cur_frame = frame_q.pop_front();
                    else cur_frame = pack_bm();
                end
                chk("we_addr", 32'(out_addr), 32'(exp_addr));
                chk("we_data", 32'(out_data), 32'(model_word(exp_addr, cur_frame)));
                chk("busy_during_we", 32'(out_busy), 32'd1);
                cap[out_addr] = out_data;
                exp_addr++;
            end
            if (out_IR_START) begin
                chk("words_before_start", 32'(exp_addr), 32'(NW));
                chk("start_without_we", 32'(out_we), 32'd0);
                exp_addr = 0;
                start_cyc = cyc;
                n_start++;
            end
        end else if (out_IR_START) begin
            n_start++;
        end
    end

    task automatic write_row(input int r, input logic [31:0] d);
        @(posedge in_clk); #1;
        in_bm_we = 1'b1; in_bm_addr = 3'(r); in_bm_data = d;
        tb_bm[r] = d;
        @(posedge in_clk); #1;
        in_bm_we = 1'b0;
    endtask

    task automatic pulse_commit();
        @(posedge in_clk); #1;
        in_commit = 1'b1;
        commit_cyc = cyc;
        @(posedge in_clk); #1;
        in_commit = 1'b0;
    endtask

    task automatic wait_start();
        int  s0 = n_start;
        bit  seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(posedge in_clk);
            if (n_start != s0) seen = 1'b1;
        end
        chk("start_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_addr(input int a);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge in_clk);
            if (out_we && out_addr == 8'(a)) seen = 1'b1;
        end
        chk("addr_seen", 32'(seen), 32'd1);
    endtask

    // Driver leaves idle for a few cycles after the start pulse
    task automatic ack();
        @(posedge in_clk); #1;
        in_IR_READY = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        in_IR_READY = 1'b1;
    endtask

    initial begin
        int s0;
        int nwe;
        int rdy_cyc;
        logic [255:0] pin;
        for (int r = 0; r < 8; r++) tb_bm[r] = 32'h0;

        // Reset state
        #12;
        chk("rst_we", 32'(out_we), 32'd0);
        chk("rst_start", 32'(out_IR_START), 32'd0);
        chk("rst_busy", 32'(out_busy), 32'd0);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        in_rst = 1'b1;
        chk_en = 1'b1;

        // Pin the model against hand-computed words
        pin = '0;
        pin[31:0] = 32'hF000_000F;
        chk("model_addr4", 32'(model_word(4, pin)), 32'h0A08);
        chk("model_addr20", 32'(model_word(20, pin)), 32'h01F0);
        chk("model_addr23", 32'(model_word(23, pin)), 32'h010F);
        chk("model_addr60", 32'(model_word(60, pin)), 32'h0000);

        // Full frame
        write_row(0, 32'hF000_000F);
        frame_q.push_back(pack_bm());
        pulse_commit();
        wait_start();
        chk("first_we_latency", 32'(first_we_cyc - commit_cyc), 32'd2);
        chk("start_latency", 32'(start_cyc - commit_cyc), 32'd134);
        chk("cap4", 32'(cap[4]), 32'h0A08);
        chk("cap20", 32'(cap[20]), 32'h01F0);
        chk("cap23", 32'(cap[23]), 32'h010F);
        chk("cap60", 32'(cap[60]), 32'h0000);
        chk("cap131", 32'(cap[131]), 32'h0000);
        chk("busy_before_ack", 32'(out_busy), 32'd1);
        ack();
        chk("busy_after_ack", 32'(out_busy), 32'd0);

        // Driver busy: commit held off until ready rises
        in_IR_READY = 1'b0;
        write_row(3, 32'h1234_5678);
        frame_q.push_back(pack_bm());
        pulse_commit();
        nwe = 0;
        repeat (50) begin
            @(negedge in_clk);
            if (out_we) nwe++;
        end
        chk("no_we_while_not_ready", 32'(nwe), 32'd0);
        chk("busy_while_waiting", 32'(out_busy), 32'd1);
        @(posedge in_clk); #1;
        in_IR_READY = 1'b1;
        rdy_cyc = cyc;
        wait_start();
        chk("we_after_ready", 32'(first_we_cyc - rdy_cyc), 32'd1);
        chk("busy_cap32", 32'(cap[32]), 32'h0412);
        ack();

        // Shadow isolation: row 7 rewritten mid-frame
        write_row(7, 32'hAAAA_5555);
        frame_q.push_back(pack_bm());
        pulse_commit();
        wait_addr(30);
        write_row(7, 32'h1234_ABCD);
        wait_start();
        chk("iso_old48", 32'(cap[48]), 32'h08AA);
        chk("iso_old49", 32'(cap[49]), 32'h08AA);
        chk("iso_old50", 32'(cap[50]), 32'h0855);
        chk("iso_old51", 32'(cap[51]), 32'h0855);
        ack();
        frame_q.push_back(pack_bm());
        pulse_commit();
        wait_start();
        chk("iso_new48", 32'(cap[48]), 32'h0812);
        chk("iso_new49", 32'(cap[49]), 32'h0834);
        chk("iso_new50", 32'(cap[50]), 32'h08AB);
        chk("iso_new51", 32'(cap[51]), 32'h08CD);
        ack();

        // Coalescing: three commits during WRITE give one extra frame
        s0 = n_start;
        frame_q.push_back(pack_bm());
        pulse_commit();
        wait_addr(10);
        write_row(0, 32'h1111_1111);
        pulse_commit();
        wait_addr(30);
        write_row(0, 32'h2222_2222);
        pulse_commit();
        wait_addr(50);
        pulse_commit();
        frame_q.push_back(pack_bm());
        wait_start();
        ack();
        wait_start();
        chk("coalesce_cap20", 32'(cap[20]), 32'h0122);
        ack();
        repeat (200) @(posedge in_clk);
        chk("coalesce_frames", 32'(n_start - s0), 32'd2);
        chk("coalesce_queue_empty", 32'(frame_q.size()), 32'd0);
        chk("coalesce_idle_busy", 32'(out_busy), 32'd0);

        // Reset mid-WRITE
        frame_q.push_back(pack_bm());
        pulse_commit();
        wait_addr(40);
        chk_en = 1'b0;
        #1;
        in_rst = 1'b0;
        #1;
        chk("midrst_we", 32'(out_we), 32'd0);
        chk("midrst_start", 32'(out_IR_START), 32'd0);
        chk("midrst_busy", 32'(out_busy), 32'd0);
        chk("midrst_addr", 32'(out_addr), 32'd0);
        s0 = n_start;
        repeat (3) @(posedge in_clk);
        #1;
        in_rst = 1'b1;
        for (int r = 0; r < 8; r++) tb_bm[r] = 32'h0;
        frame_q.delete();
        exp_addr = 0;
        chk_en = 1'b1;
        repeat (200) @(posedge in_clk);
        chk("midrst_no_start", 32'(n_start - s0), 32'd0);
        chk("midrst_busy_idle", 32'(out_busy), 32'd0);

`ifdef LED_FB_AUTO_REFRESH_EN
        // Auto refresh: frames arrive without commits
        for (int k = 0; k < 2; k++) begin
            frame_q.push_back(pack_bm());
            wait_start();
            ack();
        end
`else
        // No auto refresh: idle stays idle
        s0 = n_start;
        repeat (300) @(posedge in_clk);
        chk("no_auto_frame", 32'(n_start - s0), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
